mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl_if.sv | 33 +++
 rtl/mac_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mac_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - handshake, memory-address, MAC and result signals of the layer sequencer
interface mac_seq_ctrl_if #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10
);
  localparam int XAW = $clog2(N_IN);
  localparam int WAW = $clog2(N_IN * N_OUT);
  localparam int OAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic           start;
  logic [XAW-1:0] x_addr;
  logic [WAW-1:0] w_addr;
  logic           mac_clr;
  logic           mac_en;
  logic [15:0]    mac_o;
  logic           res_valid;
  logic [OAW-1:0] res_idx;
  logic [15:0]    res_data;
  logic           busy;
  logic           done;

  // Sequencer side: drives addresses, MAC controls and results.
  modport master (
    input  start, mac_o,
    output x_addr, w_addr, mac_clr, mac_en, res_valid, res_idx, res_data, busy, done
  );

  // Environment side: memories, MAC and the layer requester.
  modport slave (
    output start, mac_o,
    input  x_addr, w_addr, mac_clr, mac_en, res_valid, res_idx, res_data, busy, done
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dense-layer dot-product sequencer driving memories and an fp16 MAC
module mac_seq_ctrl #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10
) (
  input logic           clk,
  input logic           rst,
  mac_seq_ctrl_if.master bus
);
  localparam int XAW = $clog2(N_IN);
  localparam int WAW = $clog2(N_IN * N_OUT);
  localparam int OAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [OAW-1:0] i_q, i_d;
  logic [XAW-1:0] j_q, j_d;
  logic [WAW-1:0] wa_q, wa_d;
  logic [XAW-1:0] x_addr_q, x_addr_d;
  logic [WAW-1:0] w_addr_q, w_addr_d;
  logic           mac_en_q, mac_en_d;

  // State and counter registers; reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      wa_q     <= '0;
      x_addr_q <= '0;
      w_addr_q <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      wa_q     <= wa_d;
      x_addr_q <= x_addr_d;
      w_addr_q <= w_addr_d;
      mac_en_q <= mac_en_d;
    end
  end

  // Next state and counter updates; wa runs on across neurons so weights stay row-major.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    wa_d     = wa_q;
    x_addr_d = x_addr_q;
    w_addr_d = w_addr_q;
    // Memory data arrives one cycle after the address, so MAC enable trails RUN by one.
    mac_en_d = (state_q == S_RUN);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLR;
          i_d     = '0;
          j_d     = '0;
          wa_d    = '0;
        end
      end
      S_CLR: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        x_addr_d = j_q;
        w_addr_d = wa_q;
        wa_d     = wa_q + WAW'(1);
        if (j_q == XAW'(N_IN - 1)) begin
          j_d     = '0;
          state_d = S_DRAIN;
        end else begin
          j_d = j_q + XAW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (i_q == OAW'(N_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + OAW'(1);
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; addresses show the live counters in RUN and hold otherwise.
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.mac_clr   = (state_q == S_CLR);
    bus.mac_en    = mac_en_q;
    bus.res_valid = (state_q == S_WRITE);
    bus.res_idx   = (state_q == S_WRITE) ? i_q : '0;
    bus.res_data  = (state_q == S_WRITE) ? bus.mac_o : 16'h0000;
    bus.x_addr    = (state_q == S_RUN) ? j_q : x_addr_q;
    bus.w_addr    = (state_q == S_RUN) ? wa_q : w_addr_q;
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl with behavioural memories and MAC
module tb_mac_seq_ctrl;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int P     = N_IN + 3;
  localparam int LAST  = N_OUT * P + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;

  mac_seq_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  mac_seq_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] x_mem [N_IN];
  logic [15:0] w_mem [N_IN*N_OUT];
  logic [15:0] x_q, w_q;
  real         acc = 0.0;

  function automatic real fp2r(input logic [15:0] h);
    int  e;
    real m;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    if (e >= 15) for (int k = 15; k < e; k++) m = m * 2.0;
    else         for (int k = e; k < 15; k++) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2fp(input real v);
    int          e;
    int          man;
    logic [15:0] r;
    if (v <= 0.0) return 16'h0000;
    e = 15;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    man = $rtoi((v - 1.0) * 1024.0 + 0.5);
    r = {1'b0, e[4:0], man[9:0]};
    return r;
  endfunction

  // Memories with one-cycle read latency and a registered accumulator.
  always @(posedge clk) begin
    x_q <= x_mem[bus.x_addr];
    w_q <= w_mem[bus.w_addr];
    if (bus.mac_clr === 1'b1)     acc <= 0.0;
    else if (bus.mac_en === 1'b1) acc <= acc + fp2r(x_q) * fp2r(w_q);
  end
  assign bus.mac_o = r2fp(acc);

  typedef struct {
    int          idx;
    logic [15:0] data;
  } res_t;
  res_t sb [$];

  // Result scoreboard and clear/enable exclusivity, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (bus.mac_clr === 1'b1 && bus.mac_en === 1'b1) begin
        bad++;
        $display("FAIL clr_en_overlap t=%0t got clr=1 en=1 want not both", $time);
      end
      if (bus.res_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result idx=%0d data=%h want no result", bus.res_idx, bus.res_data);
        end else begin
          res_t e;
          e = sb.pop_front();
          total++;
          if (int'(bus.res_idx) !== e.idx) begin
            bad++;
            $display("FAIL res_idx got=%0d want=%0d", bus.res_idx, e.idx);
          end
          total++;
          if (bus.res_data !== e.data) begin
            bad++;
            $display("FAIL res_data idx=%0d got=%h want=%h", e.idx, bus.res_data, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_layer(input int n_res);
    res_t r;
    for (int k = 0; k < n_res; k++) begin
      r.idx  = k;
      r.data = (k == 0) ? 16'h4900 : 16'h4500;
      sb.push_back(r);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [31:0] got;
    got = {bus.x_addr, bus.w_addr, bus.mac_clr, bus.mac_en, bus.res_valid,
           bus.res_idx, bus.res_data, bus.busy, bus.done};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL %s outputs got=%h want=0", tag, got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("reset_idle");
    mon_on = 1'b1;
  endtask

  task automatic test_layer();
    int n, off;
    logic eb, ed, ec, ee, er;
    push_layer(N_OUT);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= LAST + 1; c++) begin
      n   = (c - 1) / P;
      off = c - n * P;
      eb  = (c <= LAST);
      ed  = (c == LAST);
      ec  = (c < LAST) && (off == 1);
      ee  = (c < LAST) && (off >= 3) && (off <= N_IN + 2);
      er  = (c < LAST) && (off == P);
      total++;
      if ({bus.busy, bus.done, bus.mac_clr, bus.mac_en, bus.res_valid} !== {eb, ed, ec, ee, er}) begin
        bad++;
        $display("FAIL ctrl c=%0d got busy,done,clr,en,rv=%b want=%b", c,
                 {bus.busy, bus.done, bus.mac_clr, bus.mac_en, bus.res_valid}, {eb, ed, ec, ee, er});
      end
      if (c < LAST && off >= 2 && off <= N_IN + 1) begin
        total++;
        if (int'(bus.w_addr) !== n * N_IN + off - 2 || int'(bus.x_addr) !== off - 2) begin
          bad++;
          $display("FAIL addr c=%0d got w=%0d x=%0d want w=%0d x=%0d", c, bus.w_addr, bus.x_addr,
                   n * N_IN + off - 2, off - 2);
        end
      end
      tick();
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL layer_results_missing got=%0d pending want=0", sb.size());
    end
  endtask

  task automatic test_start_held();
    bit seen;
    push_layer(N_OUT);
    push_layer(N_OUT);
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= LAST + 2; c++) begin
      total++;
      if (bus.busy !== ((c <= LAST) || (c == LAST + 2))) begin
        bad++;
        $display("FAIL held_busy c=%0d got=%b", c, bus.busy);
      end
      total++;
      if (bus.done !== (c == LAST)) begin
        bad++;
        $display("FAIL held_done c=%0d got=%b want=%b", c, bus.done, c == LAST);
      end
      if (c == LAST + 2) begin
        total++;
        if (bus.mac_clr !== 1'b1) begin
          bad++;
          $display("FAIL held_restart_clr got=%b want=1", bus.mac_clr);
        end
        bus.start = 1'b0;
      end
      tick();
    end
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL held_second_done got=timeout want=done");
    end
    tick();
    total++;
    if (bus.busy !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL held_end got busy=%b pending=%0d want busy=0 pending=0", bus.busy, sb.size());
    end
  endtask

  task automatic test_reset_mid_run();
    push_layer(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < P + 3; c++) tick();
    rst = 1'b1;
    tick();
    check_zero("mid_run_reset");
    rst = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL mid_run_first_result got pending=%0d want=0", sb.size());
    end
    tick();
    test_layer();
  endtask

  task automatic test_start_with_rst();
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL start_rst_busy got=%b want=0", bus.busy);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    check_zero("start_rst_idle");
  endtask

  initial begin
    x_mem[0] = 16'h3C00; x_mem[1] = 16'h4000; x_mem[2] = 16'h4200; x_mem[3] = 16'h4400;
    for (int k = 0; k < N_IN; k++) begin
      w_mem[k]        = 16'h3C00;
      w_mem[N_IN + k] = 16'h3800;
    end
    bus.start = 1'b0;
    test_reset();
    test_layer();
    test_start_held();
    test_reset_mid_run();
    test_start_with_rst();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
